// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe engine: decodes ASCII commands from the UART receiver, keeps the
// 3x3 board, detects win/draw and answers with one or two ASCII bytes.
module ttt_game_ctrl #(
  parameter bit FIRST_PLAYER = 1'b0,
  parameter int TX_TIMEOUT   = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_data_valid,
  input  logic [7:0]  rx_byte,
  input  logic        tx_done,
  output logic        tx_data_valid,
  output logic [7:0]  tx_byte,
  output logic [17:0] board,
  output logic        cur_player,
  output logic [1:0]  status,
  output logic [3:0]  move_count,
  output logic [7:0]  drop_count,
  output logic        busy
);

  localparam int TW = $clog2(TX_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TX_TIMEOUT - 1);

  localparam logic [7:0] CHR_X  = 8'h58;
  localparam logic [7:0] CHR_O  = 8'h4F;
  localparam logic [7:0] CHR_W  = 8'h57;
  localparam logic [7:0] CHR_D  = 8'h44;
  localparam logic [7:0] CHR_N  = 8'h4E;
  localparam logic [7:0] CHR_Q  = 8'h3F;
  localparam logic [7:0] CHR_UR = 8'h52;
  localparam logic [7:0] CHR_LR = 8'h72;

  localparam logic [1:0] ST_PLAY = 2'b00;
  localparam logic [1:0] ST_XWIN = 2'b01;
  localparam logic [1:0] ST_OWIN = 2'b10;
  localparam logic [1:0] ST_DRAW = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EVAL   = 3'd2,
    S_SEND1  = 3'd3,
    S_WAIT1  = 3'd4,
    S_SEND2  = 3'd5,
    S_WAIT2  = 3'd6
  } state_e;

  state_e        state_q;
  logic [7:0]    cmd_q;
  logic [17:0]   board_q;
  logic          cur_player_q;
  logic [1:0]    status_q;
  logic [3:0]    move_count_q;
  logic [7:0]    drop_count_q;
  logic [7:0]    drop_count_d;
  logic [7:0]    byte1_q;
  logic [7:0]    byte2_q;
  logic          byte2_pend_q;
  logic [7:0]    tx_byte_q;
  logic          tx_valid_q;
  logic [TW-1:0] tmo_q;

  logic          is_digit_s;
  logic [3:0]    cell_idx_s;
  logic [17:0]   board_shift_s;
  logic [1:0]    cell_val_s;
  logic [1:0]    mark_s;
  logic          win_s;

  // True when mark m owns any complete row, column or diagonal of b.
  function automatic logic line_win(input logic [17:0] b, input logic [1:0] m);
    logic [8:0] own;
    for (int i = 0; i < 9; i++) begin
      own[i] = (b[2*i +: 2] == m);
    end
    return (own[0] & own[1] & own[2]) | (own[3] & own[4] & own[5]) |
           (own[6] & own[7] & own[8]) | (own[0] & own[3] & own[6]) |
           (own[1] & own[4] & own[7]) | (own[2] & own[5] & own[8]) |
           (own[0] & own[4] & own[8]) | (own[2] & own[4] & own[6]);
  endfunction

  // Command decode and line evaluation on the registered board.
  always_comb begin
    is_digit_s    = (cmd_q >= 8'h31) && (cmd_q <= 8'h39);
    cell_idx_s    = is_digit_s ? (cmd_q[3:0] - 4'd1) : 4'd0;
    board_shift_s = board_q >> {cell_idx_s, 1'b0};
    cell_val_s    = board_shift_s[1:0];
    mark_s        = cur_player_q ? 2'b10 : 2'b01;
    win_s         = line_win(board_q, mark_s);
  end

  // Bytes arriving while a command is in progress are only counted.
  always_comb begin
    drop_count_d = drop_count_q;
    if (rx_data_valid && (state_q != S_IDLE) && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end else begin
      drop_count_d = drop_count_q;
    end
  end

  // Game FSM with registered game state and transmit strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cmd_q        <= 8'h00;
      board_q      <= 18'd0;
      cur_player_q <= FIRST_PLAYER;
      status_q     <= ST_PLAY;
      move_count_q <= 4'd0;
      drop_count_q <= 8'd0;
      byte1_q      <= 8'h00;
      byte2_q      <= 8'h00;
      byte2_pend_q <= 1'b0;
      tx_byte_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      tmo_q        <= '0;
    end else begin
      tx_valid_q   <= 1'b0;
      drop_count_q <= drop_count_d;
      case (state_q)
        S_IDLE: begin
          if (rx_data_valid) begin
            cmd_q   <= rx_byte;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          byte2_pend_q <= 1'b0;
          if (is_digit_s && (status_q == ST_PLAY) && (cell_val_s == 2'b00)) begin
            board_q      <= board_q | (18'(mark_s) << {cell_idx_s, 1'b0});
            move_count_q <= move_count_q + 4'd1;
            state_q      <= S_EVAL;
          end else if ((cmd_q == CHR_UR) || (cmd_q == CHR_LR)) begin
            board_q      <= 18'd0;
            move_count_q <= 4'd0;
            status_q     <= ST_PLAY;
            cur_player_q <= FIRST_PLAYER;
            byte1_q      <= CHR_N;
            state_q      <= S_SEND1;
          end else begin
            byte1_q <= CHR_Q;
            state_q <= S_SEND1;
          end
        end
        S_EVAL: begin
          byte1_q <= cur_player_q ? CHR_O : CHR_X;
          // A completed line on the ninth move is a win, not a draw.
          if (win_s) begin
            status_q     <= cur_player_q ? ST_OWIN : ST_XWIN;
            byte2_q      <= CHR_W;
            byte2_pend_q <= 1'b1;
          end else if (move_count_q == 4'd9) begin
            status_q     <= ST_DRAW;
            byte2_q      <= CHR_D;
            byte2_pend_q <= 1'b1;
          end else begin
            cur_player_q <= ~cur_player_q;
          end
          state_q <= S_SEND1;
        end
        S_SEND1: begin
          tx_byte_q  <= byte1_q;
          tx_valid_q <= 1'b1;
          tmo_q      <= '0;
          state_q    <= S_WAIT1;
        end
        S_WAIT1: begin
          if (tx_done) begin
            state_q <= byte2_pend_q ? S_SEND2 : S_IDLE;
          end else if (tmo_q == TMO_LAST) begin
            byte2_pend_q <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_SEND2: begin
          tx_byte_q    <= byte2_q;
          tx_valid_q   <= 1'b1;
          byte2_pend_q <= 1'b0;
          tmo_q        <= '0;
          state_q      <= S_WAIT2;
        end
        S_WAIT2: begin
          if (tx_done || (tmo_q == TMO_LAST)) begin
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_data_valid = tx_valid_q;
  assign tx_byte       = tx_byte_q;
  assign board         = board_q;
  assign cur_player    = cur_player_q;
  assign status        = status_q;
  assign move_count    = move_count_q;
  assign drop_count    = drop_count_q;
  assign busy          = (state_q != S_IDLE);

endmodule
